// File: rtl/truth_table_scanner_pkg.sv
// Shared types and width helpers for the truth-table scanner and its settle timer.
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } scan_state_t;

   localparam int DEF_N_IN  = 2;
   localparam int DEF_N_VEC = 1 << DEF_N_IN;

   // Width of a counter that must hold every value 0..max_val (never narrower than 1 bit).
   function automatic int cnt_width(input int max_val);
      if (max_val < 1) begin
         return 1;
      end else begin
         return $clog2(max_val + 1);
      end
   endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable down-counter that stretches each applied vector; zero marks the sample cycle.
module settle_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   // Load wins over decrement; the count saturates at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {W{1'b0}};
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != {W{1'b0}})) begin
         cnt_q <= cnt_q - W'(1'b1);
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/truth_table_scanner.sv
// Drives every input combination onto a single-output gate, captures its truth table
// and compares it against EXPECT, reporting pass, mismatch count and first failing index.
module truth_table_scanner
   import scan_pkg::*;
#(
   parameter int                    N_IN   = 2,
   parameter int                    HOLD   = 2,
   parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [N_IN-1:0]        dut_in,
   input  logic                   dut_out,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [(1<<N_IN)-1:0]   table_out,
   output logic [N_IN:0]          mismatch_cnt,
   output logic                   fail_valid,
   output logic [N_IN-1:0]        first_fail_idx
);

   localparam int              NV       = 1 << N_IN;
   localparam int              CW       = N_IN + 1;
   localparam int              TW       = cnt_width(HOLD);
   localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);

   scan_state_t     state_q;
   logic [N_IN-1:0] idx_q;
   logic [N_IN-1:0] dut_in_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic [NV-1:0]   table_q;
   logic [CW-1:0]   mcnt_q;
   logic            fvalid_q;
   logic [N_IN-1:0] ffidx_q;

   logic            tmr_load_s;
   logic            tmr_dec_s;
   logic            tmr_zero_s;
   logic            mismatch_s;
   logic            last_s;
   logic [CW-1:0]   mcnt_d;

   settle_timer #(.W(TW)) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load_s),
      .load_val (TW'(HOLD)),
      .dec      (tmr_dec_s),
      .zero     (tmr_zero_s)
   );

   assign mismatch_s = (dut_out != EXPECT[idx_q]);
   assign last_s     = (idx_q == LAST_IDX);
   assign mcnt_d     = mismatch_s ? (mcnt_q + CW'(1'b1)) : mcnt_q;

   // Timer reloads on an accepted start and after every non-final sample.
   always_comb begin
      tmr_load_s = 1'b0;
      tmr_dec_s  = 1'b0;
      case (state_q)
         IDLE: begin
            tmr_load_s = start;
         end
         APPLY: begin
            if (!tmr_zero_s) begin
               tmr_dec_s = 1'b1;
            end else begin
               tmr_load_s = !last_s;
            end
         end
         default: begin
            tmr_load_s = 1'b0;
            tmr_dec_s  = 1'b0;
         end
      endcase
   end

   // Scan FSM; pass is computed from the final sample so it is valid alongside done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= {N_IN{1'b0}};
         dut_in_q <= {N_IN{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         table_q  <= {NV{1'b0}};
         mcnt_q   <= {CW{1'b0}};
         fvalid_q <= 1'b0;
         ffidx_q  <= {N_IN{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q  <= APPLY;
                  idx_q    <= {N_IN{1'b0}};
                  dut_in_q <= {N_IN{1'b0}};
                  busy_q   <= 1'b1;
                  pass_q   <= 1'b0;
                  table_q  <= {NV{1'b0}};
                  mcnt_q   <= {CW{1'b0}};
                  fvalid_q <= 1'b0;
                  ffidx_q  <= {N_IN{1'b0}};
               end
            end
            APPLY: begin
               if (tmr_zero_s) begin
                  table_q[idx_q] <= dut_out;
                  mcnt_q         <= mcnt_d;
                  if (mismatch_s && !fvalid_q) begin
                     fvalid_q <= 1'b1;
                     ffidx_q  <= idx_q;
                  end
                  if (last_s) begin
                     state_q  <= DONE;
                     dut_in_q <= {N_IN{1'b0}};
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     pass_q   <= (mcnt_d == {CW{1'b0}});
                  end else begin
                     idx_q    <= idx_q + N_IN'(1'b1);
                     dut_in_q <= idx_q + N_IN'(1'b1);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q  <= IDLE;
               dut_in_q <= {N_IN{1'b0}};
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

   assign dut_in         = dut_in_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign table_out      = table_q;
   assign mismatch_cnt   = mcnt_q;
   assign fail_valid     = fvalid_q;
   assign first_fail_idx = ffidx_q;

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Upstream stimulus-and-capture stage for the single-output gate blocks (and_gate and its siblings). On `start`, the block drives every input combination 0 … 2^N_IN−1 onto the gate's inputs and holds each one for a fixed settle time. It then samples the gate output into a truth-table register, compares it against a parameterised expected table, and reports pass/fail, mismatch count and the first failing index. It replaces hand-written `for`-loop stimulus in the gate benches, and it is synthesizable, so it also serves as an on-chip self-test.

## Interface
Parameters:
- `N_IN`, 2, number of gate inputs (1–6).
- `HOLD`, 2, extra settle cycles per vector (≥0); each vector is driven for HOLD+1 cycles.
- `EXPECT`, 4'b1000, expected output per index, bit k = gate output for input k, width 2^N_IN (default = AND).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  begin a scan; accepted only in IDLE.
- `dut_in`  out  N_IN  vector to gate; bit N_IN−1 = first gate input (`{a,b} = idx`).
- `dut_out`  in  1  gate output.
- `busy`  out  1  high while vectors are applied.
- `done`  out  1  one-cycle pulse at end of scan.
- `pass`  out  1  1 when last completed scan had zero mismatches.
- `table_out`  out  2^N_IN  captured truth table, bit k = sample for vector k.
- `mismatch_cnt`  out  N_IN+1  number of mismatching indices.
- `fail_valid`  out  1  at least one mismatch seen.
- `first_fail_idx`  out  N_IN  lowest mismatching index; valid when fail_valid.

## Operation
- States: IDLE, APPLY, DONE.
- IDLE: `dut_in`=0, busy=0. If `start`=1 on an edge:
  - go to APPLY;
  - idx←0, hold_cnt←HOLD;
  - clear table_out, mismatch_cnt, fail_valid, first_fail_idx, pass.
- APPLY: `dut_in`=idx, busy=1. On each edge:
  - if hold_cnt≠0: hold_cnt−1.
  - else sample: table_out[idx]←dut_out.
    - If dut_out≠EXPECT[idx], mismatch_cnt+1.
    - If also fail_valid=0, set fail_valid, first_fail_idx←idx.
    - Then, if idx=2^N_IN−1, go to DONE.
    - Otherwise idx+1 and hold_cnt←HOLD.
- DONE: done=1, busy=0, `dut_in`=0.
  - pass←(mismatch_cnt==0), registered on DONE entry, so it is valid in the same cycle as done.
  - Next edge goes to IDLE unconditionally.
- `start` in APPLY or DONE is ignored (no restart, no queueing). `start` held high causes back-to-back scans with exactly one IDLE cycle between them.
- Results (table_out, counts, pass) hold until the next accepted start or rst.
- idx never wraps: the scan terminates at the last index. mismatch_cnt maximum is 2^N_IN, so it needs N_IN+1 bits.
- rst: synchronous, highest priority, including mid-scan. It forces IDLE and zeroes every output: dut_in, busy, done, pass, table_out, mismatch_cnt, fail_valid, first_fail_idx.

## Timing
- Reset value of all outputs: 0.
- With start sampled at edge E0:
  - vector k is on `dut_in` from E0+k(HOLD+1) for HOLD+1 cycles;
  - it is sampled at edge E0+(k+1)(HOLD+1).
- DONE (done=1) is entered at edge E0+2^N_IN(HOLD+1) and lasts 1 cycle.
- Scan latency, start edge to done: 2^N_IN·(HOLD+1) cycles.
- `dut_out` must settle combinationally within HOLD+1 cycles of `dut_in` changing. It is sampled in the last cycle of each vector.
- table_out, mismatch_cnt and first_fail_idx update one edge after each sample point.

## Structure
- Package `scan_pkg`:
  - state enum `scan_state_t` {IDLE, APPLY, DONE};
  - localparam `N_VEC = 1<<N_IN`;
  - count-width helper function.
- One natural sub-module: `settle_timer`, a loadable down-counter of width $clog2(HOLD+1) with a zero flag. It is instantiated once. The FSM, index counter and comparator stay in the top.

## Test plan
- Default params + and_gate:
  - start pulse;
  - dut_in steps 0,1,2,3, each for 3 cycles;
  - done at cycle 12 after start, table_out=4'b1000, mismatch_cnt=0, pass=1, fail_valid=0.
- Gate replaced by OR, EXPECT=AND: table_out=4'b1110, mismatch_cnt=2, fail_valid=1, first_fail_idx=1, pass=0.
- dut_out stuck at 1: table_out=4'b1111, mismatch_cnt=3, first_fail_idx=0. Stuck at 0: mismatch_cnt=1, first_fail_idx=3.
- HOLD=0:
  - each vector lasts 1 cycle, done 4 cycles after start;
  - start re-pulsed during APPLY has no effect on sequence or timing;
  - start held high gives a second scan starting 1 cycle after done.
- rst asserted while idx=2:
  - next edge: busy=0, dut_in=0, table_out=0, mismatch_cnt=0;
  - a later start performs a full fresh scan with correct results.
- N_IN=3, EXPECT=8'h80 (3-input AND): done 24 cycles after start, pass=1. Injected fault at index 5 gives first_fail_idx=5, mismatch_cnt=1.
